// File: rtl/vga_pkg.sv
// Shared definitions for the tile colour path.
// Provides sizing constants, the commit FSM state type, and the mapping from
// a {row[2:0],col[2:0]} tile address to a storage index 0..48, where any
// row >= N_ROWS collapses onto the single background entry.
package vga_pkg;

  localparam int unsigned COLOR_W     = 8;
  localparam int unsigned TILE_ADDR_W = 6;
  localparam int unsigned N_COLS      = 8;
  localparam int unsigned N_ROWS      = 6;
  localparam int unsigned N_TILES     = 48;
  localparam int unsigned BG_INDEX    = 48;
  localparam int unsigned N_ENTRIES   = N_TILES + 1;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COPY
  } state_t;

  // For rows below N_ROWS, row*8+col is exactly the address itself.
  function automatic logic [TILE_ADDR_W-1:0] tile_index(input logic [TILE_ADDR_W-1:0] addr);
    if (addr[5:3] >= 3'(N_ROWS)) begin
      return TILE_ADDR_W'(BG_INDEX);
    end
    return addr;
  endfunction

endpackage

// File: rtl/tile_bank.sv
// 49x8 flop-based colour register file.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   we/waddr/wdata    single write port (index 0..48)
//   raddr/rdata       registered read port, 1-cycle latency, resets to 0
//   cp_addr/cp_data   combinational read used as the copy-back source
// Reset: tile entries 0, background entry BG_RESET.
module tile_bank
  import vga_pkg::*;
#(
  parameter logic [COLOR_W-1:0] BG_RESET = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [TILE_ADDR_W-1:0] waddr,
  input  logic [COLOR_W-1:0]     wdata,
  input  logic [TILE_ADDR_W-1:0] raddr,
  output logic [COLOR_W-1:0]     rdata,
  input  logic [TILE_ADDR_W-1:0] cp_addr,
  output logic [COLOR_W-1:0]     cp_data
);

  logic [COLOR_W-1:0] mem [N_ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        mem[i[5:0]] <= (i == BG_INDEX) ? BG_RESET : '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
    end
  end

  // The copy engine reads the front bank while the display also reads it, so
  // it needs its own unregistered port.
  always_comb begin
    cp_data = mem[cp_addr];
  end

endmodule

// File: rtl/tile_color_buffer.sv
// Double-buffered tile colour store feeding the VGA output stage.
// Ports:
//   clk, rst        pixel clock, synchronous active-high reset
//   rd_addr/rd_data display read {row,col} -> colour, 1-cycle latency,
//                   rows >= 6 return the background colour
//   frame_start     frame boundary pulse; the only point a bank swap happens
//   wr_valid/wr_ready/wr_addr/wr_data
//                   host write into the back bank, accepted only in IDLE
//   commit_req      request to publish the back bank at the next frame_start
//   commit_busy     high while a commit is pending or copying back
// After a swap, the new front bank is copied into the new back bank one entry
// per cycle so the host continues editing from the displayed image.
module tile_color_buffer
  import vga_pkg::*;
#(
  parameter logic [COLOR_W-1:0] BG_RESET = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TILE_ADDR_W-1:0] rd_addr,
  output logic [COLOR_W-1:0]     rd_data,
  input  logic                   frame_start,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [TILE_ADDR_W-1:0] wr_addr,
  input  logic [COLOR_W-1:0]     wr_data,
  input  logic                   commit_req,
  output logic                   commit_busy
);

  state_t                 state, state_nxt;
  logic                   front_sel;
  logic                   sel_q;
  logic                   swap;
  logic [TILE_ADDR_W-1:0] idx;

  logic                   back_we;
  logic [TILE_ADDR_W-1:0] back_addr;
  logic [COLOR_W-1:0]     back_data;
  logic [TILE_ADDR_W-1:0] rd_index;
  logic [COLOR_W-1:0]     b0_rdata, b1_rdata;
  logic [COLOR_W-1:0]     b0_cp, b1_cp;
  logic [COLOR_W-1:0]     front_cp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      front_sel <= 1'b0;
      sel_q     <= 1'b0;
      idx       <= '0;
    end else begin
      state <= state_nxt;
      // sel_q tracks which bank produced the registered read, so the read in
      // the swap cycle still comes from the old front bank.
      sel_q <= front_sel;
      if (swap) begin
        front_sel <= ~front_sel;
      end
      if (state == PENDING) begin
        idx <= '0;
      end else if (state == COPY && idx != TILE_ADDR_W'(BG_INDEX)) begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    wr_ready    = 1'b0;
    commit_busy = 1'b0;
    swap        = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (commit_req) begin
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        commit_busy = 1'b1;
        if (frame_start) begin
          swap      = 1'b1;
          state_nxt = COPY;
        end
      end
      COPY: begin
        commit_busy = 1'b1;
        if (idx == TILE_ADDR_W'(BG_INDEX)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Back bank write source: host in IDLE, copy engine in COPY.
  always_comb begin
    front_cp  = front_sel ? b1_cp : b0_cp;
    back_we   = (state == IDLE && wr_valid) || (state == COPY);
    back_addr = (state == COPY) ? idx : tile_index(wr_addr);
    back_data = (state == COPY) ? front_cp : wr_data;
    rd_index  = tile_index(rd_addr);
    rd_data   = sel_q ? b1_rdata : b0_rdata;
  end

  tile_bank #(.BG_RESET(BG_RESET)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we      (back_we & front_sel),
    .waddr   (back_addr),
    .wdata   (back_data),
    .raddr   (rd_index),
    .rdata   (b0_rdata),
    .cp_addr (idx),
    .cp_data (b0_cp)
  );

  tile_bank #(.BG_RESET(BG_RESET)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we      (back_we & ~front_sel),
    .waddr   (back_addr),
    .wdata   (back_data),
    .raddr   (rd_index),
    .rdata   (b1_rdata),
    .cp_addr (idx),
    .cp_data (b1_cp)
  );

endmodule
